// File: rtl/vga_fb_scanout.sv
// VGA scan-out engine: programmable sync timing, frame-buffer read addressing
// with pixel/line replication, double-buffer select and a latency-matched
// sync/data pipeline so pixel data lines up with the sync pins.
module vga_fb_scanout #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int HSYNC_POL   = 0,
   parameter int VSYNC_POL   = 0,
   parameter int SCALE_SHIFT = 0,
   parameter int RD_LAT      = 1,
   parameter int CW          = 4,
   parameter int AW          = 19
) (
   input  logic            vgaclk,
   input  logic            rst,
   input  logic            fb_sel,
   output logic            fb_rd,
   output logic [AW:0]     fb_addr,
   input  logic [3*CW-1:0] fb_data,
   output logic            hsync,
   output logic            vsync,
   output logic            de,
   output logic [CW-1:0]   red,
   output logic [CW-1:0]   green,
   output logic [CW-1:0]   blue,
   output logic            frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CNT_MAX = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
   localparam int CNTW    = $clog2(CNT_MAX);
   localparam int L       = RD_LAT + 2;
   localparam int SW      = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;

   localparam logic [CNTW-1:0] H_LAST   = CNTW'(H_TOTAL - 1);
   localparam logic [CNTW-1:0] V_LAST   = CNTW'(V_TOTAL - 1);
   localparam logic [CNTW-1:0] H_ACT_C  = CNTW'(H_ACTIVE);
   localparam logic [CNTW-1:0] V_ACT_C  = CNTW'(V_ACTIVE);
   localparam logic [CNTW-1:0] HS_START = CNTW'(H_ACTIVE + H_FP);
   localparam logic [CNTW-1:0] HS_END   = CNTW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNTW-1:0] VS_START = CNTW'(V_ACTIVE + V_FP);
   localparam logic [CNTW-1:0] VS_END   = CNTW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [SW-1:0]   SUB_MAX  = SW'((1 << SCALE_SHIFT) - 1);
   localparam logic [AW-1:0]   ROW_STEP = AW'(H_ACTIVE >> SCALE_SHIFT);
   localparam logic            HS_ON    = (HSYNC_POL != 0);
   localparam logic            VS_ON    = (VSYNC_POL != 0);

   // One pipeline slot of timing information travelling towards the pins.
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic fs;
   } sync_t;

   localparam sync_t SYNC_IDLE = sync_t'({~HS_ON, ~VS_ON, 1'b0, 1'b0});

   logic [CNTW-1:0]   r_hc;
   logic [CNTW-1:0]   r_vc;
   logic [SW-1:0]     r_hsub;
   logic [SW-1:0]     r_vsub;
   logic [AW-1:0]     r_col;
   logic [AW-1:0]     r_row;
   logic              r_buf;
   logic              r_fb_rd;
   logic [AW:0]       r_fb_addr;
   logic [3*CW-1:0]   r_rgb;
   sync_t             r_pipe [L];

   logic              w_h_wrap;
   logic              w_v_last;
   logic              w_active;
   sync_t             w_raw;

   assign w_h_wrap = (r_hc == H_LAST);
   assign w_v_last = (r_vc == V_LAST);
   assign w_active = (r_hc < H_ACT_C) && (r_vc < V_ACT_C);

   // Raster counters: hc every clock, vc on each line wrap.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge vgaclk or posedge rst) begin
      if (rst) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (w_h_wrap) begin
         r_hc <= '0;
         r_vc <= w_v_last ? '0 : r_vc + CNTW'(1);
      end else begin
         r_hc <= r_hc + CNTW'(1);
      end
   end

   // Multiplier-free offset: column and row-base counters with replication
   // sub-counters; row base steps once per 2^S active lines.
   always_ff @(posedge vgaclk or posedge rst) begin
      if (rst) begin
         r_hsub <= '0;
         r_col  <= '0;
         r_vsub <= '0;
         r_row  <= '0;
      end else if (w_h_wrap) begin
         r_hsub <= '0;
         r_col  <= '0;
         if (w_v_last) begin
            r_vsub <= '0;
            r_row  <= '0;
         end else if (r_vc < V_ACT_C) begin
            if (r_vsub == SUB_MAX) begin
               r_vsub <= '0;
               r_row  <= r_row + ROW_STEP;
            end else begin
               r_vsub <= r_vsub + SW'(1);
            end
         end
      end else if (w_active) begin
         if (r_hsub == SUB_MAX) begin
            r_hsub <= '0;
            r_col  <= r_col + AW'(1);
         end else begin
            r_hsub <= r_hsub + SW'(1);
         end
      end
   end

   // Buffer select only changes at the frame wrap so a frame never tears.
   always_ff @(posedge vgaclk or posedge rst) begin
      if (rst)
         r_buf <= 1'b0;
      else if (w_h_wrap && w_v_last)
         r_buf <= fb_sel;
   end

   // RAM read request; address holds during blanking.
   always_ff @(posedge vgaclk or posedge rst) begin
      if (rst) begin
         r_fb_rd   <= 1'b0;
         r_fb_addr <= '0;
      end else begin
         r_fb_rd <= w_active;
         if (w_active)
            r_fb_addr <= {r_buf, r_row + r_col};
      end
   end

   // Timing flags derived from the current counter state.
   // NOTE: every field gets its default before any condition so no latch
   // is inferred.
   always_comb begin
      w_raw = SYNC_IDLE;
      if ((r_hc >= HS_START) && (r_hc < HS_END))
         w_raw.hs = HS_ON;
      if ((r_vc >= VS_START) && (r_vc < VS_END))
         w_raw.vs = VS_ON;
      w_raw.de = w_active;
      w_raw.fs = (r_hc == '0) && (r_vc == '0);
   end

   // Delay timing flags by L stages to meet the returning RAM data.
   // NOTE: this delay line is reset, unlike a RAM, because its contents
   // reach the pins directly after reset release.
   always_ff @(posedge vgaclk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < L; i++)
            r_pipe[i] <= SYNC_IDLE;
      end else begin
         r_pipe[0] <= w_raw;
         for (int i = 1; i < L; i++)
            r_pipe[i] <= r_pipe[i-1];
      end
   end

   // Pixel register, blanked whenever the aligned de is low.
   always_ff @(posedge vgaclk or posedge rst) begin
      if (rst)
         r_rgb <= '0;
      else
         r_rgb <= r_pipe[L-2].de ? fb_data : '0;
   end

   assign fb_rd       = r_fb_rd;
   assign fb_addr     = r_fb_addr;
   assign hsync       = r_pipe[L-1].hs;
   assign vsync       = r_pipe[L-1].vs;
   assign de          = r_pipe[L-1].de;
   assign frame_start = r_pipe[L-1].fs;
   assign red         = r_rgb[CW-1:0];
   assign green       = r_rgb[2*CW-1:CW];
   assign blue        = r_rgb[3*CW-1:2*CW];

endmodule
